// File: rtl/mem.sv
// Data-memory stage: word-indexed 32-bit RAM with a combinational read and a write on the clock edge.
// Result returns either the loaded word or the ALU result to write-back.
module mem #(
  parameter int DEPTH     = 64,
  parameter int ADDR_BITS = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WD,
  input  logic        MemWrite,
  input  logic        MemtoReg,
  output logic [31:0] Result
);

  logic [31:0]      r_mem [DEPTH];
  logic [DEPTH-1:0] w_wsel;
  logic             w_in_range;
  logic [31:0]      w_rd;

  // All 32 address bits take part in the range check, so high bits never alias onto a word.
  assign w_in_range = (ALUResult < 32'(DEPTH));

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wsel
      assign w_wsel[gi] = MemWrite && (ALUResult == 32'(gi));
    end
  endgenerate

  // Reset clears every word and takes priority over a store on the same edge.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (reset) begin
        r_mem[i] <= 32'd0;
      end else if (w_wsel[i]) begin
        r_mem[i] <= WD;
      end
    end
  end

  always_comb begin
    w_rd = 32'd0;
    if (w_in_range) begin
      w_rd = r_mem[ALUResult[ADDR_BITS-1:0]];
    end
  end

  assign Result = MemtoReg ? w_rd : ALUResult;

endmodule

// File: tb/tb_mem.sv
// Self-checking bench for mem: directed vector table, a held-store sequence,
// and randomized traffic checked against an array model of the memory.
module tb_mem;

  localparam int DEPTH = 64;

  logic        clk;
  logic        reset;
  logic [31:0] ALUResult;
  logic [31:0] WD;
  logic        MemWrite;
  logic        MemtoReg;
  logic [31:0] Result;

  int checks = 0;
  int errors = 0;

  mem #(.DEPTH(DEPTH), .ADDR_BITS(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .ALUResult(ALUResult),
    .WD       (WD),
    .MemWrite (MemWrite),
    .MemtoReg (MemtoReg),
    .Result   (Result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic [31:0] alu;
    logic [31:0] wd;
    logic        we;
    logic        m2r;
    logic [31:0] exp_pre;
    logic [31:0] exp_post;
  } vec_t;

  vec_t vecs[$];

  // Reference memory: plain array updated from the behavioural rules.
  logic [31:0] model [DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Drive inputs after a negedge, check before the edge, then check after it.
  task automatic apply(input string name, input logic rst, input logic [31:0] alu,
                       input logic [31:0] wd, input logic we, input logic m2r,
                       input logic [31:0] exp_pre, input logic [31:0] exp_post);
    @(negedge clk);
    reset = rst; ALUResult = alu; WD = wd; MemWrite = we; MemtoReg = m2r;
    #2;
    check({name, "_pre"}, Result, exp_pre);
    @(posedge clk);
    #1;
    check({name, "_post"}, Result, exp_post);
    $display("txn %-12s rst=%0b alu=%08h wd=%08h we=%0b m2r=%0b result=%08h",
             name, rst, alu, wd, we, m2r, Result);
  endtask

  function automatic logic [31:0] model_result(input logic [31:0] alu, input logic m2r);
    logic [31:0] rd;
    rd = (alu < DEPTH) ? model[alu] : 32'd0;
    return m2r ? rd : alu;
  endfunction

  initial begin
    reset = 1'b1; ALUResult = '0; WD = '0; MemWrite = 1'b0; MemtoReg = 1'b0;

    // Reset edge first; contents before it are undefined so no pre-edge check.
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    vecs.push_back('{"rd12_reset",  1'b0, 32'd12,         32'd0,          1'b0, 1'b1, 32'd0,    32'd0});
    vecs.push_back('{"preload12",   1'b0, 32'd12,         32'd989,        1'b1, 1'b1, 32'd0,    32'd989});
    vecs.push_back('{"raw12",       1'b0, 32'd12,         32'd0,          1'b1, 1'b1, 32'd989,  32'd0});
    vecs.push_back('{"wr13",        1'b0, 32'd13,         32'd4554,       1'b1, 1'b1, 32'd0,    32'd4554});
    vecs.push_back('{"rd12_adj",    1'b0, 32'd12,         32'd0,          1'b0, 1'b1, 32'd0,    32'd0});
    vecs.push_back('{"wr12_alu",    1'b0, 32'd12,         32'd4554,       1'b1, 1'b0, 32'd12,   32'd12});
    vecs.push_back('{"rd12_new",    1'b0, 32'd12,         32'd0,          1'b0, 1'b1, 32'd4554, 32'd4554});
    vecs.push_back('{"wr64_oor",    1'b0, 32'd64,         32'd7,          1'b1, 1'b1, 32'd0,    32'd0});
    vecs.push_back('{"rd0",         1'b0, 32'd0,          32'd0,          1'b0, 1'b1, 32'd0,    32'd0});
    vecs.push_back('{"rd13",        1'b0, 32'd13,         32'd0,          1'b0, 1'b1, 32'd4554, 32'd4554});
    vecs.push_back('{"rst_vs_wr",   1'b1, 32'd13,         32'd99,         1'b1, 1'b1, 32'd4554, 32'd0});
    vecs.push_back('{"rd13_after",  1'b0, 32'd13,         32'd0,          1'b0, 1'b1, 32'd0,    32'd0});
    vecs.push_back('{"rd12_after",  1'b0, 32'd12,         32'd0,          1'b0, 1'b1, 32'd0,    32'd0});
    vecs.push_back('{"wr_alias",    1'b0, 32'h0100_000C,  32'd5,          1'b1, 1'b1, 32'd0,    32'd0});
    vecs.push_back('{"rd12_noalias",1'b0, 32'd12,         32'd0,          1'b0, 1'b1, 32'd0,    32'd0});
    vecs.push_back('{"wr63_top",    1'b0, 32'd63,         32'hDEAD_BEEF,  1'b1, 1'b1, 32'd0,    32'hDEAD_BEEF});
    vecs.push_back('{"pass_max",    1'b0, 32'hFFFF_FFFF,  32'd1,          1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
    vecs.push_back('{"rd63",        1'b0, 32'd63,         32'd0,          1'b0, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF});

    foreach (vecs[i])
      apply(vecs[i].name, vecs[i].rst, vecs[i].alu, vecs[i].wd, vecs[i].we, vecs[i].m2r,
            vecs[i].exp_pre, vecs[i].exp_post);

    // Holding MemWrite for several edges performs one store per edge; the last wins.
    apply("hold_wr_a", 1'b0, 32'd20, 32'd111, 1'b1, 1'b1, 32'd0,   32'd111);
    apply("hold_wr_b", 1'b0, 32'd20, 32'd222, 1'b1, 1'b1, 32'd111, 32'd222);
    apply("hold_wr_c", 1'b0, 32'd20, 32'd333, 1'b1, 1'b1, 32'd222, 32'd333);
    apply("hold_rd",   1'b0, 32'd20, 32'd0,   1'b0, 1'b1, 32'd333, 32'd333);
    // Held reset keeps everything at zero with MemtoReg=1.
    apply("rst_hold_a", 1'b1, 32'd20, 32'd5,  1'b1, 1'b1, 32'd333, 32'd0);
    apply("rst_hold_b", 1'b1, 32'd20, 32'd6,  1'b1, 1'b1, 32'd0,   32'd0);

    // Randomized traffic; the model was cleared by the held reset above.
    for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
    for (int n = 0; n < 400; n++) begin
      logic        rst, we, m2r;
      logic [31:0] alu, wd, pre, post;
      rst = ($urandom_range(0, 39) == 0);
      we  = $urandom_range(0, 1);
      m2r = ($urandom_range(0, 3) != 0);
      wd  = $urandom;
      case ($urandom_range(0, 9))
        0:       alu = $urandom;
        1:       alu = 32'(DEPTH) + $urandom_range(0, 3);
        default: alu = $urandom_range(0, DEPTH - 1);
      endcase
      pre = model_result(alu, m2r);
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
      end else if (we && alu < DEPTH) begin
        model[alu] = wd;
      end
      post = model_result(alu, m2r);
      apply($sformatf("rnd%0d", n), rst, alu, wd, we, m2r, pre, post);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
